// File: rtl/nf_pipe_pkg.sv
// Shared types and constants for the nanoFOX pipeline sequencing controller.
package nf_pipe_pkg;

    localparam int          XLEN        = 32;
    localparam int          REG_AW      = 5;
    localparam logic [4:0]  NF_REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    // x0 is hardwired to zero, so a write to it can never create a dependency.
    function automatic logic reg_match(input logic [4:0] wa,
                                       input logic [4:0] ra1,
                                       input logic [4:0] ra2);
        return (wa != NF_REG_ZERO) && ((wa == ra1) || (wa == ra2));
    endfunction

endpackage

// File: rtl/nf_hz_detect.sv
// Combinational hazard terms: data-memory wait, load-use and branch-operand hazards.
module nf_hz_detect
    import nf_pipe_pkg::*;
(
    input  logic [4:0] id_ra1,
    input  logic [4:0] id_ra2,
    input  logic       id_branch,
    input  logic [4:0] ex_wa3,
    input  logic       ex_we_rf,
    input  logic       ex_rf_src,
    input  logic [4:0] mem_wa3,
    input  logic       mem_we_rf,
    input  logic       mem_rf_src,
    input  logic       dmem_req,
    input  logic       dmem_ack,
    output logic       dm_wait,
    output logic       ld_use,
    output logic       br_haz
);

    logic ex_match;
    logic mem_match;

    assign ex_match  = reg_match(ex_wa3,  id_ra1, id_ra2);
    assign mem_match = reg_match(mem_wa3, id_ra1, id_ra2);

    assign dm_wait = dmem_req & ~dmem_ack;
    assign ld_use  = ex_we_rf & ex_rf_src & ex_match;
    // Branches compare in ID, so any EX result or a MEM load is not yet forwardable.
    assign br_haz  = id_branch & ((ex_we_rf & ex_match) |
                                  (mem_we_rf & mem_rf_src & mem_match));

endmodule

// File: rtl/nf_pipe_ctrl.sv
// Pipeline sequencing controller: fetch handshake FSM, one-entry fetch buffer,
// and the stall / flush / PC-enable priority logic for the 5-stage nanoFOX core.
module nf_pipe_ctrl
    import nf_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_ra1,
    input  logic [4:0]  id_ra2,
    input  logic        id_branch,
    input  logic        id_pc_src,
    input  logic [4:0]  ex_wa3,
    input  logic        ex_we_rf,
    input  logic        ex_rf_src,
    input  logic [4:0]  mem_wa3,
    input  logic        mem_we_rf,
    input  logic        mem_rf_src,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        pc_we,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        stall_mem,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        flush_wb
);

    fetch_state_t state;
    logic [31:0]  instr_buf;

    logic dm_wait;
    logic ld_use;
    logic br_haz;

    logic        taken;
    logic        fetch_acc;
    logic        imem_req_c;
    logic [31:0] if_instr_c;
    logic        if_valid_c;
    logic        pc_we_c;
    logic        stall_if_c;
    logic        stall_id_c;
    logic        stall_ex_c;
    logic        stall_mem_c;
    logic        flush_id_c;
    logic        flush_ex_c;
    logic        flush_wb_c;

    nf_hz_detect u_hz_detect (
        .id_ra1     (id_ra1),
        .id_ra2     (id_ra2),
        .id_branch  (id_branch),
        .ex_wa3     (ex_wa3),
        .ex_we_rf   (ex_we_rf),
        .ex_rf_src  (ex_rf_src),
        .mem_wa3    (mem_wa3),
        .mem_we_rf  (mem_we_rf),
        .mem_rf_src (mem_rf_src),
        .dmem_req   (dmem_req),
        .dmem_ack   (dmem_ack),
        .dm_wait    (dm_wait),
        .ld_use     (ld_use),
        .br_haz     (br_haz)
    );

    always_comb begin
        stall_if_c  = 1'b0;
        stall_id_c  = 1'b0;
        stall_ex_c  = 1'b0;
        stall_mem_c = 1'b0;
        flush_ex_c  = 1'b0;
        flush_wb_c  = 1'b0;

        // A pending data access freezes everything up to MEM and masks ID hazards.
        if (dm_wait) begin
            stall_if_c  = 1'b1;
            stall_id_c  = 1'b1;
            stall_ex_c  = 1'b1;
            stall_mem_c = 1'b1;
            flush_wb_c  = 1'b1;
        end else if (ld_use | br_haz) begin
            stall_if_c  = 1'b1;
            stall_id_c  = 1'b1;
            flush_ex_c  = 1'b1;
        end

        taken      = id_pc_src & ~stall_id_c;
        fetch_acc  = 1'b0;
        imem_req_c = 1'b0;
        if_valid_c = 1'b0;
        if_instr_c = imem_rdata;
        flush_id_c = taken;

        case (state)
            FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack & ~taken) begin
                    fetch_acc  = 1'b1;
                    if_valid_c = ~stall_if_c;
                end
                if (~imem_ack & ~stall_id_c)
                    flush_id_c = 1'b1;
            end
            HOLD: begin
                if_instr_c = instr_buf;
                if_valid_c = ~stall_if_c & ~taken;
            end
            DROP: begin
                imem_req_c = 1'b1;
                if (~stall_id_c)
                    flush_id_c = 1'b1;
            end
            default: begin
                imem_req_c = 1'b0;
            end
        endcase

        // A fetch buffered during a stall still advances the PC; taken is already stall-gated.
        pc_we_c = fetch_acc | taken;
    end

    always_comb begin
        imem_req  = 1'b0;
        if_instr  = '0;
        if_valid  = 1'b0;
        pc_we     = 1'b0;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_wb  = 1'b0;
        if (!rst) begin
            imem_req  = imem_req_c;
            if_instr  = if_instr_c;
            if_valid  = if_valid_c;
            pc_we     = pc_we_c;
            stall_if  = stall_if_c;
            stall_id  = stall_id_c;
            stall_ex  = stall_ex_c;
            stall_mem = stall_mem_c;
            flush_id  = flush_id_c;
            flush_ex  = flush_ex_c;
            flush_wb  = flush_wb_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            instr_buf <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack & ~taken & stall_if_c) begin
                        instr_buf <= imem_rdata;
                        state     <= HOLD;
                    end else if (~imem_ack & taken) begin
                        state <= DROP;
                    end
                end
                HOLD: begin
                    if (~stall_if_c)
                        state <= FETCH;
                end
                DROP: begin
                    if (imem_ack)
                        state <= FETCH;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nf_pipe_ctrl.sv
// Directed-vector bench for nf_pipe_ctrl; control outputs are packed into one word.
module tb_nf_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_ra1, id_ra2;
    logic        id_branch, id_pc_src;
    logic [4:0]  ex_wa3;
    logic        ex_we_rf, ex_rf_src;
    logic [4:0]  mem_wa3;
    logic        mem_we_rf, mem_rf_src;
    logic        dmem_req, dmem_ack;
    logic        imem_req, imem_ack;
    logic [31:0] imem_rdata, if_instr;
    logic        if_valid, pc_we;
    logic        stall_if, stall_id, stall_ex, stall_mem;
    logic        flush_id, flush_ex, flush_wb;

    int errs   = 0;
    int checks = 0;

    localparam logic [31:0] R  = 32'h200;
    localparam logic [31:0] V  = 32'h100;
    localparam logic [31:0] P  = 32'h080;
    localparam logic [31:0] SI = 32'h040;
    localparam logic [31:0] SD = 32'h020;
    localparam logic [31:0] SE = 32'h010;
    localparam logic [31:0] SM = 32'h008;
    localparam logic [31:0] FI = 32'h004;
    localparam logic [31:0] FE = 32'h002;
    localparam logic [31:0] FW = 32'h001;

    logic [31:0] ctrl;
    assign ctrl = {22'b0, imem_req, if_valid, pc_we, stall_if, stall_id,
                   stall_ex, stall_mem, flush_id, flush_ex, flush_wb};

    nf_pipe_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .id_ra1     (id_ra1),
        .id_ra2     (id_ra2),
        .id_branch  (id_branch),
        .id_pc_src  (id_pc_src),
        .ex_wa3     (ex_wa3),
        .ex_we_rf   (ex_we_rf),
        .ex_rf_src  (ex_rf_src),
        .mem_wa3    (mem_wa3),
        .mem_we_rf  (mem_we_rf),
        .mem_rf_src (mem_rf_src),
        .dmem_req   (dmem_req),
        .dmem_ack   (dmem_ack),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_instr   (if_instr),
        .if_valid   (if_valid),
        .pc_we      (pc_we),
        .stall_if   (stall_if),
        .stall_id   (stall_id),
        .stall_ex   (stall_ex),
        .stall_mem  (stall_mem),
        .flush_id   (flush_id),
        .flush_ex   (flush_ex),
        .flush_wb   (flush_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        id_ra1 = 0; id_ra2 = 0; id_branch = 0; id_pc_src = 0;
        ex_wa3 = 0; ex_we_rf = 0; ex_rf_src = 0;
        mem_wa3 = 0; mem_we_rf = 0; mem_rf_src = 0;
        dmem_req = 0; dmem_ack = 0; imem_ack = 0; imem_rdata = 0;
    endtask

    task automatic ex_load(input logic [4:0] wa);
        ex_we_rf = 1; ex_rf_src = 1; ex_wa3 = wa;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        imem_ack = 1; imem_rdata = 32'h11111111; dmem_req = 1;
        tick(); tick();
        check("rst_ctrl", ctrl, 32'h0);
        check("rst_instr", if_instr, 32'h0);

        // Back-to-back fetches right after reset release
        rst = 0; dmem_req = 0; imem_rdata = 32'h00100093;
        settle();
        check("fetch0_ctrl", ctrl, R | V | P);
        check("fetch0_instr", if_instr, 32'h00100093);
        tick();
        imem_rdata = 32'h00200113;
        settle();
        check("fetch1_ctrl", ctrl, R | V | P);
        check("fetch1_instr", if_instr, 32'h00200113);
        tick();

        // Load-use on x5, then x0 destination which must not match
        imem_ack = 0; ex_load(5); id_ra1 = 5;
        settle();
        check("lduse_ctrl", ctrl, R | SI | SD | FE);
        tick();
        clear_inputs();
        settle();
        check("lduse_after", ctrl, R | FI);
        ex_load(0); id_ra1 = 0;
        settle();
        check("lduse_x0", ctrl, R | FI);
        tick();

        // Fetch completes during load-use: buffered, presented next cycle
        clear_inputs();
        ex_load(5); id_ra1 = 5; imem_ack = 1; imem_rdata = 32'hDEADBEEF;
        settle();
        check("hold_capture", ctrl, R | P | SI | SD | FE);
        tick();
        clear_inputs();
        settle();
        check("hold_present", ctrl, V);
        check("hold_instr", if_instr, 32'hDEADBEEF);
        tick();
        check("hold_exit", ctrl, R | FI);

        // Taken branch with fetch pending: response three cycles later is dropped
        id_pc_src = 1;
        settle();
        check("drop_taken", ctrl, R | P | FI);
        tick();
        id_pc_src = 0;
        settle();
        check("drop_wait0", ctrl, R | FI);
        tick();
        check("drop_wait1", ctrl, R | FI);
        tick();
        imem_ack = 1; imem_rdata = 32'hBAD0BAD0;
        settle();
        check("drop_ack", ctrl, R | FI);
        tick();
        imem_rdata = 32'h00300193;
        settle();
        check("drop_refetch", ctrl, R | V | P);
        check("drop_refetch_instr", if_instr, 32'h00300193);
        tick();

        // Data-memory wait with a simultaneous load-use
        clear_inputs();
        dmem_req = 1; ex_load(5); id_ra1 = 5;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("dmwait%0d", i), ctrl, R | SI | SD | SE | SM | FW);
            tick();
        end
        dmem_ack = 1;
        settle();
        check("dmwait_lduse", ctrl, R | SI | SD | FE);
        tick();
        clear_inputs();
        settle();
        check("dmwait_done", ctrl, R | FI);
        tick();

        // Branch on x7 loaded in EX: two stalls, then taken
        id_branch = 1; id_ra2 = 7; id_pc_src = 1; ex_load(7);
        settle();
        check("br_ld_ex", ctrl, R | SI | SD | FE);
        tick();
        ex_we_rf = 0; ex_rf_src = 0; ex_wa3 = 0;
        mem_wa3 = 7; mem_we_rf = 1; mem_rf_src = 1;
        settle();
        check("br_ld_mem", ctrl, R | SI | SD | FE);
        tick();
        mem_wa3 = 0; mem_we_rf = 0; mem_rf_src = 0;
        settle();
        check("br_taken", ctrl, R | P | FI);
        tick();

        // Now in DROP: ALU result in EX stalls, x0 and MEM ALU result do not
        id_pc_src = 0; ex_we_rf = 1; ex_wa3 = 7;
        settle();
        check("br_alu_ex", ctrl, R | SI | SD | FE);
        ex_wa3 = 0; id_ra2 = 0;
        settle();
        check("br_x0", ctrl, R | FI);
        clear_inputs();
        id_branch = 1; id_ra2 = 7; mem_wa3 = 7; mem_we_rf = 1;
        settle();
        check("br_mem_alu", ctrl, R | FI);

        // Reset while in DROP returns to FETCH
        clear_inputs();
        rst = 1; imem_ack = 1; imem_rdata = 32'h00400213;
        settle();
        check("rst_mid_ctrl", ctrl, 32'h0);
        tick();
        rst = 0;
        settle();
        check("rst_mid_fetch", ctrl, R | V | P);
        check("rst_mid_instr", if_instr, 32'h00400213);
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
